fetch_stage: RTL and testbench

Instruction-fetch pipeline stage and producer side of the IF/ID interface. Holds the PC and issues word reads to the instruction-memory port with a req/ready handshake. Fills the IF/ID register (instruction plus PC+4) and applies redirects that Decode returns over the id_if_* signals, using MIPS single-delay-slot semantics. Inserts NOP bubbles on memory wait and holds on hazard stall.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// IF-stage bundle: IF/ID register outputs, Decode redirect inputs, hazard stall,
// and the instruction-memory read port. master = fetch stage, slave = its surroundings.
interface fetch_stage_if;
  logic [31:0] if_id_instruc;
  logic [31:0] if_id_nextpc;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_pcindex;
  logic [31:0] id_if_rega;
  logic        hz_if_stall;
  logic        if_mc_req;
  logic [31:0] if_mc_addr;
  logic [31:0] mc_if_rdata;
  logic        mc_if_ready;

  modport master (
    output if_id_instruc, if_id_nextpc, if_mc_req, if_mc_addr,
    input  id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext, id_if_pcindex,
           id_if_rega, hz_if_stall, mc_if_rdata, mc_if_ready
  );

  modport slave (
    input  if_id_instruc, if_id_nextpc, if_mc_req, if_mc_addr,
    output id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext, id_if_pcindex,
           id_if_rega, hz_if_stall, mc_if_rdata, mc_if_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, memory read handshake and IF/ID register with one delay slot.
// One word per cycle at zero wait states; memory waits insert NOP bubbles, hazard stall holds.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] if_id_instruc_q;
  logic [31:0] if_id_nextpc_q;
  logic        pend_v;
  logic [31:0] pend_tgt;
  logic [31:0] held;

  logic [31:0] tgt_raw;
  logic [31:0] tgt;
  logic        redir_act;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  logic        req;
  logic        advance;
  logic [31:0] adv_word;
  logic        capture_hold;
  logic        bubble;

  always_comb begin
    tgt_raw = bus.id_if_pcimd2ext;
    case (bus.id_if_selpctype)
      2'b01:   tgt_raw = bus.id_if_pcindex;
      2'b10:   tgt_raw = bus.id_if_rega;
      default: tgt_raw = bus.id_if_pcimd2ext;
    endcase
  end

  assign tgt       = tgt_raw & ~32'h0000_0003;
  assign redir_act = bus.id_if_selpcsource && (bus.id_if_selpctype != 2'b11);
  assign pc_plus4  = pc + 32'd4;
  // A live redirect beats an older pending one; both skip the sequential PC.
  assign pc_next   = redir_act ? tgt : (pend_v ? pend_tgt : pc_plus4);

  always_comb begin
    state_nxt    = state;
    req          = 1'b0;
    advance      = 1'b0;
    adv_word     = bus.mc_if_rdata;
    capture_hold = 1'b0;
    bubble       = 1'b0;
    case (state)
      S_BOOT: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        req = 1'b1;
        if (bus.mc_if_ready && !bus.hz_if_stall) begin
          advance = 1'b1;
        end else if (bus.mc_if_ready) begin
          capture_hold = 1'b1;
          state_nxt    = S_HOLD;
        end else if (!bus.hz_if_stall) begin
          bubble = 1'b1;
        end
      end
      S_HOLD: begin
        adv_word = held;
        if (!bus.hz_if_stall) begin
          advance   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc              <= RESET_PC;
      if_id_instruc_q <= NOP_WORD;
      if_id_nextpc_q  <= 32'h0;
      pend_v          <= 1'b0;
      pend_tgt        <= 32'h0;
      held            <= 32'h0;
    end else begin
      if (advance) begin
        if_id_instruc_q <= adv_word;
        if_id_nextpc_q  <= pc_plus4;
        pc              <= pc_next;
        pend_v          <= 1'b0;
      end else begin
        if (bubble) begin
          if_id_instruc_q <= NOP_WORD;
        end
        // Redirect arrived while the delay slot is still outstanding: remember it.
        if (redir_act) begin
          pend_v   <= 1'b1;
          pend_tgt <= tgt;
        end
      end
      if (capture_hold) begin
        held <= bus.mc_if_rdata;
      end
    end
  end

  assign bus.if_mc_req     = req;
  assign bus.if_mc_addr    = pc;
  assign bus.if_id_instruc = if_id_instruc_q;
  assign bus.if_id_nextpc  = if_id_nextpc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against an
// address-stream reference model (next address to deliver, pending redirect).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_word = 32'h0;
  logic [31:0] rdata_xor = 32'h0;

  fetch_stage_if fif ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (fif)
  );

  always #5 clock = ~clock;

  always_comb fif.mc_if_rdata = use_fixed ? fixed_word : (fif.if_mc_addr ^ rdata_xor);

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fif.id_if_selpcsource = 1'b0;
    fif.id_if_selpctype   = 2'b11;
    fif.id_if_pcimd2ext   = 32'h0;
    fif.id_if_pcindex     = 32'h0;
    fif.id_if_rega        = 32'h0;
    fif.hz_if_stall       = 1'b0;
    fif.mc_if_ready       = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    use_fixed = 1'b0;
    rdata_xor = 32'h0;
    repeat (2) cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc} !== {NOP, 32'h0}) begin
      n_fail++; $display("FAIL reset_ifid: got %h/%h want %h/0", fif.if_id_instruc, fif.if_id_nextpc, NOP);
    end
    n_checks++;
    if ({fif.if_mc_req, fif.if_mc_addr} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_req: got req=%b addr=%h want 0/0", fif.if_mc_req, fif.if_mc_addr);
    end
  endtask

  task automatic test_basic();
    reset = 1'b1;
    n_checks++;
    if (fif.if_mc_req !== 1'b0) begin
      n_fail++; $display("FAIL boot_req: got %b want 0", fif.if_mc_req);
    end
    cycle();
    n_checks++;
    if ({fif.if_mc_req, fif.if_mc_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h want 1/0", fif.if_mc_req, fif.if_mc_addr);
    end
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h0, 32'h4, 32'h4}) begin
      n_fail++; $display("FAIL seq0: got %h/%h addr=%h want 0/4 addr=4", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h4, 32'h8, 32'h8}) begin
      n_fail++; $display("FAIL seq1: got %h/%h addr=%h want 4/8 addr=8", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
  endtask

  task automatic test_wait();
    fif.mc_if_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr} !== {NOP, 32'h8, 1'b1, 32'h8}) begin
        n_fail++; $display("FAIL wait_bubble%0d: got %h/%h req=%b addr=%h want NOP/8 req=1 addr=8", i,
                           fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr);
      end
    end
    fif.mc_if_ready = 1'b1;
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h8, 32'hC, 32'hC}) begin
      n_fail++; $display("FAIL wait_arrive: got %h/%h addr=%h want 8/c addr=c", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
  endtask

  task automatic test_branch();
    repeat (2) cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h10, 32'h14, 32'h14}) begin
      n_fail++; $display("FAIL br_setup: got %h/%h addr=%h want 10/14 addr=14", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
    fif.id_if_selpcsource = 1'b1;
    fif.id_if_selpctype   = 2'b00;
    fif.id_if_pcimd2ext   = 32'h40;
    cycle();
    idle_inputs();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h14, 32'h18, 32'h40}) begin
      n_fail++; $display("FAIL br_delay_slot: got %h/%h addr=%h want 14/18 addr=40", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h40, 32'h44, 32'h44}) begin
      n_fail++; $display("FAIL br_target: got %h/%h addr=%h want 40/44 addr=44", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
  endtask

  task automatic test_jr_pending();
    fif.mc_if_ready       = 1'b0;
    fif.id_if_selpcsource = 1'b1;
    fif.id_if_selpctype   = 2'b10;
    fif.id_if_rega        = 32'h83;
    for (int i = 0; i < 3; i++) begin
      cycle();
      idle_inputs();
      fif.mc_if_ready = 1'b0;
      n_checks++;
      if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {NOP, 32'h44, 32'h44}) begin
        n_fail++; $display("FAIL jr_wait%0d: got %h/%h addr=%h want NOP/44 addr=44", i,
                           fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
      end
    end
    fif.mc_if_ready = 1'b1;
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h44, 32'h48, 32'h80}) begin
      n_fail++; $display("FAIL jr_pend_apply: got %h/%h addr=%h want 44/48 addr=80", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr} !== {32'h80, 32'h84, 32'h84}) begin
      n_fail++; $display("FAIL jr_target: got %h/%h addr=%h want 80/84 addr=84", fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_addr);
    end
  endtask

  task automatic test_stall_hold();
    use_fixed       = 1'b1;
    fixed_word      = 32'hDEAD_BEEF;
    fif.hz_if_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      use_fixed       = 1'b0;
      fif.mc_if_ready = 1'b0;
      n_checks++;
      if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req} !== {32'h80, 32'h84, 1'b0}) begin
        n_fail++; $display("FAIL hold%0d: got %h/%h req=%b want 80/84 req=0", i,
                           fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req);
      end
    end
    fif.hz_if_stall = 1'b0;
    cycle();
    fif.mc_if_ready = 1'b1;
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr} !== {32'hDEAD_BEEF, 32'h88, 1'b1, 32'h88}) begin
      n_fail++; $display("FAIL hold_release: got %h/%h req=%b addr=%h want deadbeef/88 req=1 addr=88",
                         fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr);
    end
  endtask

  task automatic test_reset_mid();
    fif.id_if_selpcsource = 1'b1;
    fif.id_if_selpctype   = 2'b01;
    fif.id_if_pcindex     = 32'h20;
    cycle();
    idle_inputs();
    fif.mc_if_ready = 1'b0;
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr} !== {NOP, 32'h8C, 1'b1, 32'h20}) begin
      n_fail++; $display("FAIL rst_mid_wait: got %h/%h req=%b addr=%h want NOP/8c req=1 addr=20",
                         fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr} !== {NOP, 32'h0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_async: got %h/%h req=%b addr=%h want NOP/0 req=0 addr=0",
                         fif.if_id_instruc, fif.if_id_nextpc, fif.if_mc_req, fif.if_mc_addr);
    end
    fif.mc_if_ready = 1'b1;
    repeat (2) cycle();
    reset = 1'b1;
    n_checks++;
    if (fif.if_mc_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_boot: got req=%b want 0", fif.if_mc_req);
    end
    cycle();
    n_checks++;
    if ({fif.if_mc_req, fif.if_mc_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_restart: got req=%b addr=%h want 1/0", fif.if_mc_req, fif.if_mc_addr);
    end
    cycle();
    n_checks++;
    if ({fif.if_id_instruc, fif.if_id_nextpc} !== {32'h0, 32'h4}) begin
      n_fail++; $display("FAIL rst_mid_first: got %h/%h want 0/4", fif.if_id_instruc, fif.if_id_nextpc);
    end
  endtask

  // Model: words are delivered in program order; a redirect makes the word after
  // the next delivered one come from the target (latest redirect wins).
  task automatic test_random();
    logic [31:0] m_addr, m_instr, m_npc, m_pend, t;
    logic        m_pend_v, m_hold, deliver;
    reset = 1'b0;
    idle_inputs();
    rdata_xor = 32'hFFFF_FFFF;
    cycle();
    reset = 1'b1;
    cycle();
    m_addr = 32'h0; m_instr = NOP; m_npc = 32'h0; m_pend = 32'h0; m_pend_v = 1'b0; m_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      n_checks++;
      if ({fif.if_id_instruc, fif.if_id_nextpc} !== {m_instr, m_npc}) begin
        n_fail++; $display("FAIL rnd_ifid@%0d: got %h/%h want %h/%h", i, fif.if_id_instruc, fif.if_id_nextpc, m_instr, m_npc);
      end
      n_checks++;
      if (fif.if_mc_req !== !m_hold || (!m_hold && fif.if_mc_addr !== m_addr)) begin
        n_fail++; $display("FAIL rnd_req@%0d: got req=%b addr=%h want req=%b addr=%h", i,
                           fif.if_mc_req, fif.if_mc_addr, !m_hold, m_addr);
      end
      fif.mc_if_ready       = ($urandom_range(0, 3) != 0);
      fif.hz_if_stall       = ($urandom_range(0, 4) == 0);
      fif.id_if_selpcsource = ($urandom_range(0, 9) == 0);
      fif.id_if_selpctype   = 2'($urandom_range(0, 3));
      fif.id_if_pcimd2ext   = $urandom & 32'h0003_FFFF;
      fif.id_if_pcindex     = $urandom & 32'h0003_FFFF;
      fif.id_if_rega        = $urandom & 32'h0003_FFFF;
      if (fif.id_if_selpcsource && fif.id_if_selpctype != 2'b11) begin
        t = (fif.id_if_selpctype == 2'b00) ? fif.id_if_pcimd2ext :
            (fif.id_if_selpctype == 2'b01) ? fif.id_if_pcindex : fif.id_if_rega;
        m_pend   = {t[31:2], 2'b00};
        m_pend_v = 1'b1;
      end
      deliver = m_hold ? !fif.hz_if_stall : (fif.mc_if_ready && !fif.hz_if_stall);
      if (deliver) begin
        m_instr  = ~m_addr;
        m_npc    = m_addr + 32'd4;
        m_addr   = m_pend_v ? m_pend : m_addr + 32'd4;
        m_pend_v = 1'b0;
        m_hold   = 1'b0;
      end else if (!m_hold && fif.mc_if_ready) begin
        m_hold = 1'b1;
      end else if (!m_hold && !fif.hz_if_stall) begin
        m_instr = NOP;
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_branch();
    test_jr_pending();
    test_stall_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
